// File: rtl/svm_weight_sequencer.sv
// -----------------------------------------------------------------------------
// svm_weight_sequencer
//
// Purpose:
//   Fetches the NUM_WEIGHT weights of one selected weight vector from a
//   synchronous weight ROM (1-cycle read latency) and streams them, in index
//   order, to the MAC datapath over a valid/ready interface. One pass per
//   accepted start; a 1-cycle done pulse closes the pass.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   start      in   1-cycle pass request, sampled only in IDLE
//   vec_sel    in   vector to fetch, captured with start
//   abort      in   cancel the current pass (ignored in IDLE)
//   mem_ren    out  ROM read enable
//   mem_radd   out  ROM read address (holds last issued address when idle)
//   mem_rdata  in   ROM read data, valid one cycle after mem_ren
//   w_valid    out  weight stream valid
//   w_ready    in   MAC accepts weight
//   w_data     out  weight value
//   w_idx      out  feature index of w_data
//   w_last     out  high when w_idx == NUM_WEIGHT-1
//   busy       out  high from start acceptance until done
//   done       out  1-cycle pulse at end of pass
//   stall_cnt  out  (SVM_SEQ_STALL_CNT_EN only) stalled-valid cycle counter
//
// Configuration:
//   Define SVM_SEQ_STALL_CNT_EN to add the stall_cnt output and its counter.
//
// Notes:
//   mem_ren/mem_radd are decoded from registered state and the current
//   w_ready. Counting a same-cycle pop into the read credit is what lets a
//   2-entry buffer sustain one weight per cycle; all stream, busy and done
//   outputs come straight from flops.
// -----------------------------------------------------------------------------
module svm_weight_sequencer #(
  parameter int unsigned NUM_WEIGHT = 64,
  parameter int unsigned NUM_VEC    = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_WIDTH  = 6,
  parameter int unsigned VSEL_WIDTH = 2
) (
`ifdef SVM_SEQ_STALL_CNT_EN
  output logic [15:0]           stall_cnt,
`endif
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [VSEL_WIDTH-1:0] vec_sel,
  input  logic                  abort,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_radd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [IDX_WIDTH-1:0]  w_idx,
  output logic                  w_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Control state
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [IDX_WIDTH-1:0]  r_issue_cnt;
  logic [ADDR_WIDTH-1:0] r_last_radd;
  logic                  r_busy;
  logic                  r_done;

  // Read in flight: data for it is on mem_rdata this cycle
  logic                  r_rvalid;
  logic [IDX_WIDTH-1:0]  r_rd_idx;

  // 2-entry buffer: head register drives the stream, skid holds the second
  logic                  r_w_valid;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [IDX_WIDTH-1:0]  r_w_idx;
  logic                  r_w_last;
  logic                  r_sk_valid;
  logic [DATA_WIDTH-1:0] r_sk_data;
  logic [IDX_WIDTH-1:0]  r_sk_idx;

`ifdef SVM_SEQ_STALL_CNT_EN
  logic [15:0]           r_stall_cnt;
`endif

  logic                  w_start_ok;
  logic                  w_pop;
  logic [1:0]            w_occ;
  logic [1:0]            w_occ_lim;
  logic                  w_issue;
  logic [ADDR_WIDTH-1:0] w_issue_addr;
  logic                  w_active;

  // Start is honoured only for an existing vector
  assign w_start_ok   = start && (32'(vec_sel) < NUM_VEC);

  assign w_pop        = r_w_valid && w_ready;
  assign w_active     = (r_state == ST_RUN) || (r_state == ST_DRAIN);

  // Buffered entries plus the read whose data is returning this cycle
  assign w_occ        = 2'(r_w_valid) + 2'(r_sk_valid) + 2'(r_rvalid);

  // A pop this cycle frees a slot before the new read's data can land
  assign w_occ_lim    = w_pop ? 2'd3 : 2'd2;

  // Abort suppresses the read so nothing returns into the following IDLE cycle
  assign w_issue      = (r_state == ST_RUN) && !abort && (w_occ < w_occ_lim);
  assign w_issue_addr = r_base + ADDR_WIDTH'(r_issue_cnt);

  assign mem_ren      = w_issue;
  assign mem_radd     = w_issue ? w_issue_addr : r_last_radd;

  assign w_valid      = r_w_valid;
  assign w_data       = r_w_data;
  assign w_idx        = r_w_idx;
  assign w_last       = r_w_last;
  assign busy         = r_busy;
  assign done         = r_done;

`ifdef SVM_SEQ_STALL_CNT_EN
  assign stall_cnt    = r_stall_cnt;
`endif

  // Sequencer FSM, read issue, return buffer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_last_radd <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rd_idx    <= '0;
      r_w_valid   <= 1'b0;
      r_w_data    <= '0;
      r_w_idx     <= '0;
      r_w_last    <= 1'b0;
      r_sk_valid  <= 1'b0;
      r_sk_data   <= '0;
      r_sk_idx    <= '0;
    end else begin
      r_done   <= 1'b0;
      r_rvalid <= w_issue;

      if (w_issue) begin
        r_rd_idx    <= r_issue_cnt;
        r_last_radd <= w_issue_addr;
        r_issue_cnt <= r_issue_cnt + IDX_WIDTH'(1);
      end

      if (abort && (r_state != ST_IDLE)) begin
        // Flush everything, including data returning this cycle
        r_state    <= ST_IDLE;
        r_busy     <= 1'b0;
        r_w_valid  <= 1'b0;
        r_w_last   <= 1'b0;
        r_sk_valid <= 1'b0;
        r_rvalid   <= 1'b0;
      end else begin
        // Return buffer: pop from head, push returning read data
        if (w_pop) begin
          if (r_sk_valid) begin
            r_w_data <= r_sk_data;
            r_w_idx  <= r_sk_idx;
            r_w_last <= (r_sk_idx == LAST_IDX);
            if (r_rvalid) begin
              r_sk_data <= mem_rdata;
              r_sk_idx  <= r_rd_idx;
            end else begin
              r_sk_valid <= 1'b0;
            end
          end else if (r_rvalid) begin
            r_w_data <= mem_rdata;
            r_w_idx  <= r_rd_idx;
            r_w_last <= (r_rd_idx == LAST_IDX);
          end else begin
            r_w_valid <= 1'b0;
            r_w_last  <= 1'b0;
          end
        end else if (r_rvalid) begin
          if (r_w_valid) begin
            r_sk_valid <= 1'b1;
            r_sk_data  <= mem_rdata;
            r_sk_idx   <= r_rd_idx;
          end else begin
            r_w_valid <= 1'b1;
            r_w_data  <= mem_rdata;
            r_w_idx   <= r_rd_idx;
            r_w_last  <= (r_rd_idx == LAST_IDX);
          end
        end

        case (r_state)
          ST_IDLE: begin
            if (w_start_ok) begin
              r_state     <= ST_RUN;
              r_base      <= ADDR_WIDTH'(vec_sel) * ADDR_WIDTH'(NUM_WEIGHT);
              r_issue_cnt <= '0;
              r_busy      <= 1'b1;
            end
          end
          ST_RUN: begin
            if (w_issue && (r_issue_cnt == LAST_IDX)) begin
              r_state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (w_pop && r_w_last) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef SVM_SEQ_STALL_CNT_EN
  // Stalled-valid cycle counter: cleared by an accepted start, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_IDLE) && w_start_ok) begin
      r_stall_cnt <= '0;
    end else if (w_active && r_w_valid && !w_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_svm_weight_sequencer.sv
// -----------------------------------------------------------------------------
// tb_svm_weight_sequencer
//
// Scoreboard bench: each accepted pass pushes its expected weight stream and
// ROM address sequence into queues; a negedge monitor pops and compares on
// every transfer / read issue, and checks stall stability, done timing and
// read credit. ROM word k holds value k.
// -----------------------------------------------------------------------------
module tb_svm_weight_sequencer;

  localparam int unsigned NW = 64;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 6;
  localparam int unsigned VW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } item_t;

  // Main DUT signals
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [VW-1:0] vec_sel;
  logic          abort;
  logic          mem_ren;
  logic [AW-1:0] mem_radd;
  logic [DW-1:0] mem_rdata = '0;
  logic          w_valid;
  logic          w_ready = 1'b0;
  logic [DW-1:0] w_data;
  logic [IW-1:0] w_idx;
  logic          w_last;
  logic          busy;
  logic          done;

  // Second instance with NUM_VEC=3
  logic          start3;
  logic [VW-1:0] vec_sel3;
  logic          abort3;
  logic          mem_ren3;
  logic [AW-1:0] mem_radd3;
  logic [DW-1:0] mem_rdata3 = '0;
  logic          w_valid3;
  logic [DW-1:0] w_data3;
  logic [IW-1:0] w_idx3;
  logic          w_last3;
  logic          busy3;
  logic          done3;

`ifdef SVM_SEQ_STALL_CNT_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   stall_cnt3;
`endif

  svm_weight_sequencer #(
    .NUM_WEIGHT(NW), .NUM_VEC(4), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .IDX_WIDTH(IW), .VSEL_WIDTH(VW)
  ) dut (
`ifdef SVM_SEQ_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vec_sel   (vec_sel),
    .abort     (abort),
    .mem_ren   (mem_ren),
    .mem_radd  (mem_radd),
    .mem_rdata (mem_rdata),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data),
    .w_idx     (w_idx),
    .w_last    (w_last),
    .busy      (busy),
    .done      (done)
  );

  svm_weight_sequencer #(
    .NUM_WEIGHT(NW), .NUM_VEC(3), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .IDX_WIDTH(IW), .VSEL_WIDTH(VW)
  ) dut3 (
`ifdef SVM_SEQ_STALL_CNT_EN
    .stall_cnt (stall_cnt3),
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start3),
    .vec_sel   (vec_sel3),
    .abort     (abort3),
    .mem_ren   (mem_ren3),
    .mem_radd  (mem_radd3),
    .mem_rdata (mem_rdata3),
    .w_valid   (w_valid3),
    .w_ready   (1'b1),
    .w_data    (w_data3),
    .w_idx     (w_idx3),
    .w_last    (w_last3),
    .busy      (busy3),
    .done      (done3)
  );

  always #5 clk = ~clk;

  // Synchronous ROM models: word k = k, output held when read-enable low
  always @(posedge clk) begin
    if (mem_ren)  mem_rdata  <= DW'(mem_radd);
    if (mem_ren3) mem_rdata3 <= DW'(mem_radd3);
  end

  // Bookkeeping
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  item_t exp_q[$];
  logic [AW-1:0] addr_q[$];
  int    clr_gen  = 0;
  int    clr_seen = 0;
  int    issued_cnt = 0;
  int    xfer_cnt   = 0;
  int    stall_seen = 0;
  int    done_cnt   = 0;
  int    done_base  = 0;
  int    first_xfer_cyc = 0;
  int    last_xfer_cyc  = 0;
  int    ready_mode = 0;   // 0: always 1, 1: 1,0,0,1 pattern, 2: random, 3: always 0
  int    pat_ph = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
  endtask

  // w_ready driver
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: w_ready = 1'b1;
      1: begin
        w_ready = ((pat_ph % 4) == 0) || ((pat_ph % 4) == 3);
        pat_ph++;
      end
      2: w_ready = 1'($urandom_range(0, 1));
      default: w_ready = 1'b0;
    endcase
  end

  // Monitor: scoreboard pops, read-address checks, stall and done rules
  logic  prev_stall = 1'b0;
  item_t prev_item  = '0;
  logic  done_pending = 1'b0;

  always @(negedge clk) begin
    item_t e;
    item_t cur;
    cur = {w_data, w_idx, w_last};
    if (clr_seen != clr_gen) begin
      clr_seen   = clr_gen;
      issued_cnt = 0;
      xfer_cnt   = 0;
      stall_seen = 0;
    end
    if (!rst_n) begin
      prev_stall   = 1'b0;
      done_pending = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_valid", 32'(w_valid), 32'd1);
        chk("stall_hold_payload", 32'(cur), 32'(prev_item));
      end
      if (done_pending) begin
        chk("done_after_last", 32'(done), 32'd1);
        chk("busy_low_at_done", 32'(busy), 32'd0);
        done_pending = 1'b0;
        done_cnt++;
      end else if (done) begin
        chk("spurious_done", 32'(done), 32'd0);
      end
      if (w_valid && w_ready && !abort) begin
        xfer_cnt++;
        if (xfer_cnt == 1) first_xfer_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_transfer", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("w_data", 32'(w_data), 32'(e.data));
          chk("w_idx",  32'(w_idx),  32'(e.idx));
          chk("w_last", 32'(w_last), 32'(e.last));
        end
        if (w_last) begin
          done_pending  = 1'b1;
          last_xfer_cyc = cyc;
        end
      end
      if (mem_ren) begin
        issued_cnt++;
        if (addr_q.size() == 0) chk("unexpected_read", 32'(addr_q.size()), 32'd1);
        else chk("mem_radd", 32'(mem_radd), 32'(addr_q.pop_front()));
        chk("outstanding_le_2", 32'((issued_cnt - xfer_cnt) <= 2), 32'd1);
      end
      if (busy && w_valid && !w_ready) stall_seen++;
      prev_stall = w_valid && !w_ready && !abort;
      prev_item  = cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference stream for vector vs: ROM words vs*NW .. vs*NW+NW-1 in order
  task automatic start_pass(input int vs);
    item_t it;
    for (int k = 0; k < int'(NW); k++) begin
      it.data = DW'(vs * int'(NW) + k);
      it.idx  = IW'(k);
      it.last = (k == int'(NW) - 1);
      exp_q.push_back(it);
      addr_q.push_back(AW'(vs * int'(NW) + k));
    end
    clr_gen++;
    done_base = done_cnt;
    vec_sel   = VW'(vs);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((done_cnt == done_base) && (n < 3000)) begin
      tick();
      n++;
    end
    chk({nm, "_done_seen"}, 32'(done_cnt != done_base), 32'd1);
    chk({nm, "_stream_consumed"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_reads_consumed"}, 32'(addr_q.size()), 32'd0);
  endtask

  task automatic flush_model();
    exp_q.delete();
    addr_q.delete();
  endtask

`ifdef SVM_SEQ_STALL_CNT_EN
  task automatic chk_stall(input string nm);
    chk({nm, "_stall_cnt"}, 32'(stall_cnt), 32'(stall_seen));
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  found;
    int  ren3_seen;
    rst_n    = 1'b0;
    start    = 1'b0;
    vec_sel  = '0;
    abort    = 1'b0;
    start3   = 1'b0;
    vec_sel3 = '0;
    abort3   = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_mem_ren",  32'(mem_ren),  32'd0);
    chk("rst_mem_radd", 32'(mem_radd), 32'd0);
    chk("rst_w_valid",  32'(w_valid),  32'd0);
    chk("rst_w_data",   32'(w_data),   32'd0);
    chk("rst_w_idx",    32'(w_idx),    32'd0);
    chk("rst_w_last",   32'(w_last),   32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
`ifdef SVM_SEQ_STALL_CNT_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Full-rate pass, vector 2, with first-valid latency
    ready_mode = 0;
    start_pass(2);
    chk("lat_busy_after_start", 32'(busy), 32'd1);
    chk("lat_valid_c0", 32'(w_valid), 32'd0);
    tick();
    chk("lat_valid_c1", 32'(w_valid), 32'd0);
    tick();
    chk("lat_valid_c2", 32'(w_valid), 32'd1);
    chk("lat_first_data", 32'(w_data), 32'd128);
    wait_done("full_rate");
    chk("full_rate_ren_cycles", 32'(issued_cnt), 32'd64);
    chk("full_rate_burst_len", 32'(last_xfer_cyc - first_xfer_cyc + 1), 32'd64);
`ifdef SVM_SEQ_STALL_CNT_EN
    chk_stall("full_rate");
`endif

    // 1,0,0,1 ready pattern with a stray start mid-pass
    ready_mode = 1;
    start_pass(2);
    repeat (30) tick();
    vec_sel = '0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    wait_done("pattern");
`ifdef SVM_SEQ_STALL_CNT_EN
    chk_stall("pattern");
`endif

    // Long stall right after start: exactly two reads, head held
    ready_mode = 3;
    start_pass(1);
    repeat (20) tick();
    chk("stall20_reads", 32'(issued_cnt), 32'd2);
    chk("stall20_valid", 32'(w_valid), 32'd1);
    chk("stall20_data", 32'(w_data), 32'd64);
    chk("stall20_ren", 32'(mem_ren), 32'd0);
    chk("stall20_radd_hold", 32'(mem_radd), 32'd65);
    ready_mode = 0;
    wait_done("stall20");

    // Abort at w_idx 10 with ready high, then a clean pass from vector 0
    ready_mode = 0;
    start_pass(3);
    found = 0;
    for (int n = 0; n < 200 && found == 0; n++) begin
      if (w_valid && (w_idx == IW'(10))) found = 1;
      else tick();
    end
    chk("abort_idx10_reached", 32'(found), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(w_valid), 32'd0);
    chk("abort_busy",  32'(busy),    32'd0);
    chk("abort_ren",   32'(mem_ren), 32'd0);
    chk("abort_done",  32'(done),    32'd0);
    flush_model();
    repeat (5) tick();
    start_pass(0);
    wait_done("after_abort");

    // NUM_VEC=3 instance: vec_sel 3 ignored, vec_sel 2 accepted
    vec_sel3 = 2'd3;
    start3   = 1'b1;
    tick();
    start3   = 1'b0;
    ren3_seen = 0;
    for (int n = 0; n < 6; n++) begin
      if (mem_ren3 || busy3) ren3_seen = 1;
      tick();
    end
    chk("vsel_oob_no_activity", 32'(ren3_seen), 32'd0);
    chk("vsel_oob_busy", 32'(busy3), 32'd0);
    vec_sel3 = 2'd2;
    start3   = 1'b1;
    tick();
    start3   = 1'b0;
    chk("v3_busy", 32'(busy3), 32'd1);
    tick();
    tick();
    chk("v3_valid", 32'(w_valid3), 32'd1);
    chk("v3_first_data", 32'(w_data3), 32'd128);
    chk("v3_first_idx", 32'(w_idx3), 32'd0);
    chk("v3_first_last", 32'(w_last3), 32'd0);
    abort3 = 1'b1;
    tick();
    abort3 = 1'b0;
    chk("v3_abort_busy", 32'(busy3), 32'd0);
    chk("v3_abort_valid", 32'(w_valid3), 32'd0);
    chk("v3_abort_done", 32'(done3), 32'd0);

    // Asynchronous reset at w_idx 30, then restart from idx 0
    ready_mode = 0;
    start_pass(1);
    found = 0;
    for (int n = 0; n < 200 && found == 0; n++) begin
      if (w_valid && (w_idx == IW'(30))) found = 1;
      else tick();
    end
    chk("rst_idx30_reached", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_w_valid", 32'(w_valid), 32'd0);
    chk("arst_w_data",  32'(w_data),  32'd0);
    chk("arst_w_idx",   32'(w_idx),   32'd0);
    chk("arst_busy",    32'(busy),    32'd0);
    chk("arst_mem_ren", 32'(mem_ren), 32'd0);
    chk("arst_mem_radd", 32'(mem_radd), 32'd0);
    flush_model();
    tick();
    rst_n = 1'b1;
    tick();
    start_pass(1);
    wait_done("after_reset");

    // Randomized passes: random vector and random backpressure
    ready_mode = 2;
    for (int p = 0; p < 6; p++) begin
      start_pass(int'($urandom_range(0, 3)));
      wait_done("random");
`ifdef SVM_SEQ_STALL_CNT_EN
      chk_stall("random");
`endif
      repeat (int'($urandom_range(0, 3))) tick();
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
